vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the text-mode character/colour renderer.
- Produces the active-area pixel coordinates (posx, posy) that the renderer turns into screen-memory and glyph addresses.
- Produces hsync, vsync and blank, delayed by a configurable number of cycles so they line up with the renderer's RGB output.
- Also provides frame/line strobes and a free-running frame counter for cursor/attribute blink.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- PIPE_DELAY, 2, cycles of delay applied to hsync/vsync/blank; legal range 0..7

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-clock enable; counters advance only on cycles with pix_en=1
- posx  out  10  horizontal pixel coordinate (0..H_ACTIVE-1), 0 outside the active area
- posy  out  9  vertical line coordinate (0..V_ACTIVE-1), 0 outside the active area
- active  out  1  1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE (undelayed)
- hsync  out  1  horizontal sync, polarity per HS_POL, delayed PIPE_DELAY
- vsync  out  1  vertical sync, polarity per VS_POL, delayed PIPE_DELAY
- blank  out  1  1 outside the active area, delayed PIPE_DELAY
- line_start  out  1  one-cycle strobe at h_cnt==0 (undelayed)
- frame_start  out  1  one-cycle strobe at h_cnt==0 && v_cnt==0 (undelayed)
- frame_cnt  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters: h_cnt and v_cnt, both 10 bits. Elaboration error if H_TOTAL>1024, V_TOTAL>1024 or V_ACTIVE>512.
- Rising clk with pix_en=1:
  - h_cnt increments.
  - At h_cnt==H_TOTAL-1, h_cnt goes to 0 and v_cnt increments.
  - At v_cnt==V_TOTAL-1 with h_cnt==H_TOTAL-1, both go to 0 and frame_cnt increments (mod 256).
- pix_en=0: all counters, the delay line and the strobes hold; the strobes are forced 0.
- Undelayed signals (functions of the current counter registers):
  - active as defined under Ports.
  - posx = active_h ? h_cnt : 0.
  - posy = active_v ? v_cnt[8:0] : 0.
  - Note: posx is valid throughout each active line and posy throughout each active frame, independently of each other.
  - hs_raw asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Vertical sync spans whole lines, starting and ending at h_cnt==0.
- line_start = pix_en & (h_cnt==0); frame_start = line_start & (v_cnt==0). Both are 1 for exactly one pix_en cycle.
- Delay line:
  - hs_raw, vs_raw and ~active pass through a PIPE_DELAY-stage shift register that advances only on pix_en.
  - hsync, vsync and blank are taken from the last stage.
  - PIPE_DELAY=0 makes them combinational from the counters.
  - Polarity is applied at the output: hsync = hs_del ? HS_POL : ~HS_POL (vsync likewise with VS_POL).
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - h_cnt=0, v_cnt=0, frame_cnt=0.
  - Every delay stage loads the deasserted state: sync deasserted, blank=1.
  - Outputs during reset: posx=0, posy=0, active=1 (counters at 0,0), hsync=~HS_POL, vsync=~VS_POL, blank=1, strobes=0.
- After reset release:
  - The first pix_en cycle presents frame_start=1 and line_start=1.
  - blank follows active with a lag of PIPE_DELAY pix_en cycles.

Test Plan:
- Reset, then pix_en=1 constantly, defaults -> first cycle posx=0, posy=0, frame_start=1; blank=1 for 2 cycles then 0; posx reaches 639 at cycle 639, then 0 with blank=1 two cycles later.
- Run one full line -> hsync low for exactly 96 cycles, starting 2 cycles after h_cnt==656; line_start period = 800 cycles.
- Run a full frame -> vsync low for exactly 1600 cycles (2 lines), starting 2 cycles after v_cnt==490,h_cnt==0; frame_start period = 420000 cycles; frame_cnt=1.
- pix_en toggled 1/0 each clk -> every timing interval doubles in clk cycles; strobes last exactly 1 clk; no count advances on pix_en=0 cycles.
- Assert rst for 1 clk mid-hsync at v_cnt=200 -> hsync immediately high, blank=1, posy=0, frame_cnt=0; the next pix_en cycle gives frame_start=1.
- Run 256 frames with PIPE_DELAY=0, HS_POL=1 -> frame_cnt wraps to 0; hsync high exactly while 656<=h_cnt<752, same cycle as the counters.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the text-mode renderer.
// Counters, undelayed coordinates/strobes and a delayed sync/blank line.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Comparisons are done one bit wider so a 1024 boundary still fits.
    localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
    localparam logic [10:0] HS_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
    localparam logic [10:0] VS_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic        HS_A = (HS_POL != 0);
    localparam logic        VS_A = (VS_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || V_ACTIVE > 512 ||
            PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_cfg
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [7:0]  r_frame_cnt;
    logic [10:0] w_h11;
    logic [10:0] w_v11;
    logic        w_active_h;
    logic        w_active_v;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_hs_del;
    logic        w_vs_del;
    logic        w_bl_del;
    logic        w_line_start;

    // Horizontal/vertical position and frame counter, advancing on pix_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt     <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Undelayed decode of the current raster position.
    always_comb begin
        w_h11      = {1'b0, r_h_cnt};
        w_v11      = {1'b0, r_v_cnt};
        w_active_h = (w_h11 < H_ACT);
        w_active_v = (w_v11 < V_ACT);
        w_active   = w_active_h & w_active_v;
        w_hs_raw   = (w_h11 >= HS_LO) && (w_h11 < HS_HI);
        w_vs_raw   = (w_v11 >= VS_LO) && (w_v11 < VS_HI);
        // Strobes are suppressed while reset is held.
        w_line_start = pix_en & ~rst & (r_h_cnt == 10'd0);
    end

    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign w_hs_del = w_hs_raw;
            assign w_vs_del = w_vs_raw;
            assign w_bl_del = ~w_active;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_pipe;
            logic [PIPE_DELAY-1:0] r_vs_pipe;
            logic [PIPE_DELAY-1:0] r_bl_pipe;

            // Shift sync/blank toward the renderer's RGB output timing.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hs_pipe <= '0;
                    r_vs_pipe <= '0;
                    r_bl_pipe <= '1;
                end else if (pix_en) begin
                    r_hs_pipe[0] <= w_hs_raw;
                    r_vs_pipe[0] <= w_vs_raw;
                    r_bl_pipe[0] <= ~w_active;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                        r_bl_pipe[i] <= r_bl_pipe[i-1];
                    end
                end
            end

            assign w_hs_del = r_hs_pipe[PIPE_DELAY-1];
            assign w_vs_del = r_vs_pipe[PIPE_DELAY-1];
            assign w_bl_del = r_bl_pipe[PIPE_DELAY-1];
        end
    endgenerate

    // Output mapping; reset forces the deasserted state even with no delay.
    always_comb begin
        posx        = w_active_h ? r_h_cnt : 10'd0;
        posy        = w_active_v ? r_v_cnt[8:0] : 9'd0;
        active      = w_active;
        hsync       = (w_hs_del & ~rst) ? HS_A : ~HS_A;
        vsync       = (w_vs_del & ~rst) ? VS_A : ~VS_A;
        blank       = w_bl_del | rst;
        line_start  = w_line_start;
        frame_start = w_line_start & (r_v_cnt == 10'd0);
        frame_cnt   = r_frame_cnt;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked against an
// arithmetic raster model driven by the count of pix_en cycles.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_a, n_b, n_c;

    logic rst_a, rst_b, rst_c;
    logic pe_a, pe_b, pe_c;

    logic [9:0] posx_a, posx_b, posx_c;
    logic [8:0] posy_a, posy_b, posy_c;
    logic act_a, act_b, act_c;
    logic hs_a, hs_b, hs_c;
    logic vs_a, vs_b, vs_c;
    logic bl_a, bl_b, bl_c;
    logic ls_a, ls_b, ls_c;
    logic fs_a, fs_b, fs_c;
    logic [7:0] fc_a, fc_b, fc_c;

    logic [32:0] obs_a, obs_b, obs_c;
    assign obs_a = {posx_a, posy_a, act_a, hs_a, vs_a, bl_a, ls_a, fs_a, fc_a};
    assign obs_b = {posx_b, posy_b, act_b, hs_b, vs_b, bl_b, ls_b, fs_b, fc_b};
    assign obs_c = {posx_c, posy_c, act_c, hs_c, vs_c, bl_c, ls_c, fs_c, fc_c};

    // Default 640x480 geometry, delay 2, active-low syncs.
    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .pix_en(pe_a),
        .posx(posx_a), .posy(posy_a), .active(act_a),
        .hsync(hs_a), .vsync(vs_a), .blank(bl_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    // Tiny geometry (20x12 totals), delay 3.
    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .PIPE_DELAY(3)
    ) u_b (
        .clk(clk), .rst(rst_b), .pix_en(pe_b),
        .posx(posx_b), .posy(posy_b), .active(act_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    // Tiny geometry (16x8 totals), no delay, active-high syncs.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DELAY(0)
    ) u_c (
        .clk(clk), .rst(rst_c), .pix_en(pe_c),
        .posx(posx_c), .posy(posy_c), .active(act_c),
        .hsync(hs_c), .vsync(vs_c), .blank(bl_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
    );

    // Expected outputs after n pix_en cycles since reset.
    function automatic logic [32:0] model(
        input int n, input int ha, hf, hs, hb, va, vf, vs, vb,
        input bit hp, vp, input int d, input bit pe, input bit in_rst);
        int ht, vt, h, v, f, m, mh, mv;
        bit act, hsr, vsr, bl, ls, fs;
        logic hso, vso;
        logic [9:0] px;
        logic [8:0] py;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h = n % ht;
        v = (n / ht) % vt;
        f = (n / (ht * vt)) % 256;
        act = (h < ha) && (v < va);
        if (in_rst || n < d) begin
            hsr = 0; vsr = 0; bl = 1;
        end else begin
            m = n - d;
            mh = m % ht;
            mv = (m / ht) % vt;
            hsr = (mh >= ha + hf) && (mh < ha + hf + hs);
            vsr = (mv >= va + vf) && (mv < va + vf + vs);
            bl = !((mh < ha) && (mv < va));
        end
        ls = pe && !in_rst && (h == 0);
        fs = ls && (v == 0);
        hso = hsr ? hp : !hp;
        vso = vsr ? vp : !vp;
        px = (h < ha) ? 10'(h) : 10'd0;
        py = (v < va) ? 9'(v) : 9'd0;
        return {px, py, act, hso, vso, bl, ls, fs, 8'(f)};
    endfunction

    function automatic logic [32:0] exp_a(input int n, input bit pe, input bit r);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, pe, r);
    endfunction

    function automatic logic [32:0] exp_b(input int n, input bit pe, input bit r);
        return model(n, 10, 3, 4, 3, 6, 2, 2, 2, 0, 0, 3, pe, r);
    endfunction

    function automatic logic [32:0] exp_c(input int n, input bit pe, input bit r);
        return model(n, 8, 2, 3, 3, 4, 1, 2, 1, 1, 1, 0, pe, r);
    endfunction

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        pe_a = 1; pe_b = 1; pe_c = 1;
        @(negedge clk); #1;
        checks++;
        if (obs_a !== exp_a(0, 1, 1)) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a(0, 1, 1));
        end
        checks++;
        if (obs_b !== exp_b(0, 1, 1)) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b(0, 1, 1));
        end
        checks++;
        if (obs_c !== exp_c(0, 1, 1)) begin
            failures++;
            $display("FAIL reset_c got=%h exp=%h", obs_c, exp_c(0, 1, 1));
        end
    endtask

    task automatic test_line_a();
        int hs_first = -1;
        int hs_len = 0;
        int ls_prev = -1;
        int ls_per = -1;
        logic [32:0] e;
        @(negedge clk); pe_a = 0; rst_a = 0; n_a = 0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk); pe_a = 1; #1;
            e = exp_a(n_a, 1, 0);
            checks++;
            if (obs_a !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL line_a n=%0d got=%h exp=%h", n_a, obs_a, e);
            end
            if (hs_a === 1'b0 && n_a < 800) begin
                if (hs_first < 0) hs_first = n_a;
                hs_len++;
            end
            if (ls_a === 1'b1) begin
                if (ls_prev >= 0 && ls_per < 0) ls_per = n_a - ls_prev;
                ls_prev = n_a;
            end
            if (n_a == 639) begin
                checks++;
                if (posx_a !== 10'd639) begin
                    failures++;
                    $display("FAIL posx_last got=%0d exp=639", posx_a);
                end
            end
            @(posedge clk); n_a++;
        end
        checks++;
        if (hs_first != 658) begin
            failures++;
            $display("FAIL hsync_start got=%0d exp=658", hs_first);
        end
        checks++;
        if (hs_len != 96) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=96", hs_len);
        end
        checks++;
        if (ls_per != 800) begin
            failures++;
            $display("FAIL line_period got=%0d exp=800", ls_per);
        end
    endtask

    task automatic test_toggle_a();
        int ls_clks = 0;
        int hs_clks = 0;
        logic [32:0] e;
        @(negedge clk); pe_a = 0; rst_a = 1;
        @(negedge clk); rst_a = 0; n_a = 0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk); pe_a = (i % 2 == 0); #1;
            e = exp_a(n_a, pe_a, 0);
            checks++;
            if (obs_a !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL toggle_a n=%0d got=%h exp=%h", n_a, obs_a, e);
            end
            if (ls_a === 1'b1) ls_clks++;
            if (hs_a === 1'b0) hs_clks++;
            @(posedge clk); if (pe_a) n_a++;
        end
        checks++;
        if (ls_clks != 3) begin
            failures++;
            $display("FAIL toggle_strobes got=%0d exp=3", ls_clks);
        end
        checks++;
        if (hs_clks != 384) begin
            failures++;
            $display("FAIL toggle_hsync_clks got=%0d exp=384", hs_clks);
        end
        pe_a = 0;
    endtask

    task automatic test_frame_b();
        int vs_len = 0;
        int fs_prev = -1;
        int fs_per = -1;
        logic [32:0] e;
        @(negedge clk); pe_b = 0; rst_b = 0; n_b = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); pe_b = 1; #1;
            e = exp_b(n_b, 1, 0);
            checks++;
            if (obs_b !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL frame_b n=%0d got=%h exp=%h", n_b, obs_b, e);
            end
            if (vs_b === 1'b0 && n_b < 240) vs_len++;
            if (fs_b === 1'b1) begin
                if (fs_prev >= 0 && fs_per < 0) fs_per = n_b - fs_prev;
                fs_prev = n_b;
            end
            if (n_b == 240) begin
                checks++;
                if (fc_b !== 8'd1) begin
                    failures++;
                    $display("FAIL frame_cnt_b got=%0d exp=1", fc_b);
                end
            end
            @(posedge clk); n_b++;
        end
        checks++;
        if (vs_len != 40) begin
            failures++;
            $display("FAIL vsync_width got=%0d exp=40", vs_len);
        end
        checks++;
        if (fs_per != 240) begin
            failures++;
            $display("FAIL frame_period got=%0d exp=240", fs_per);
        end
    endtask

    task automatic test_random_b();
        logic [32:0] e;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); pe_b = ($urandom_range(0, 3) != 0); #1;
            e = exp_b(n_b, pe_b, 0);
            checks++;
            if (obs_b !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL random_b n=%0d got=%h exp=%h", n_b, obs_b, e);
            end
            @(posedge clk); if (pe_b) n_b++;
        end
    endtask

    task automatic test_async_rst_b();
        bit found = 0;
        logic [32:0] e;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk); pe_b = 1; #1;
            if (n_b >= 240 && (n_b % 20) == 17 && ((n_b / 20) % 12) == 3)
                found = 1;
            else begin
                @(posedge clk); n_b++;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL seek_b got=none exp=h17v3");
        end
        checks++;
        if (hs_b !== 1'b0) begin
            failures++;
            $display("FAIL pre_rst_hsync got=%b exp=0", hs_b);
        end
        #2 rst_b = 1;
        #1;
        e = exp_b(0, 1, 1);
        checks++;
        if (obs_b !== e) begin
            failures++;
            $display("FAIL async_rst_b got=%h exp=%h", obs_b, e);
        end
        @(posedge clk);
        @(negedge clk); rst_b = 0; n_b = 0; pe_b = 1; #1;
        checks++;
        if (fs_b !== 1'b1 || ls_b !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_strobe got=%b%b exp=11", fs_b, ls_b);
        end
        @(posedge clk); n_b++;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); pe_b = ($urandom_range(0, 1) != 0); #1;
            e = exp_b(n_b, pe_b, 0);
            checks++;
            if (obs_b !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL after_rst_b n=%0d got=%h exp=%h", n_b, obs_b, e);
            end
            @(posedge clk); if (pe_b) n_b++;
        end
        pe_b = 0;
    endtask

    task automatic test_wrap_c();
        int hs_hi = 0;
        logic [32:0] e;
        @(negedge clk); pe_c = 0; rst_c = 0; n_c = 0;
        for (int i = 0; i < 256 * 128 + 40; i++) begin
            @(negedge clk); pe_c = 1; #1;
            e = exp_c(n_c, 1, 0);
            checks++;
            if (obs_c !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL wrap_c n=%0d got=%h exp=%h", n_c, obs_c, e);
            end
            if (n_c < 16 && hs_c === 1'b1) hs_hi++;
            if (n_c == 255 * 128) begin
                checks++;
                if (fc_c !== 8'd255) begin
                    failures++;
                    $display("FAIL frame_255 got=%0d exp=255", fc_c);
                end
            end
            if (n_c == 256 * 128) begin
                checks++;
                if (fc_c !== 8'd0 || fs_c !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_wrap got=%0d/%b exp=0/1", fc_c, fs_c);
                end
            end
            @(posedge clk); n_c++;
        end
        checks++;
        if (hs_hi != 3) begin
            failures++;
            $display("FAIL hsync_c_width got=%0d exp=3", hs_hi);
        end
    endtask

    initial begin
        test_reset();
        test_line_a();
        test_toggle_a();
        test_frame_b();
        test_random_b();
        test_async_rst_b();
        test_wrap_c();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
